// File: rtl/jk_univ_reg.sv
// rtl/jk_univ_reg.sv - universal register: per-bit JK, load, shift left/right, up/down count
// Optional build macro: JK_UNIV_REG_SAT_EN (counter saturates instead of wrapping)
module jk_univ_reg #(
  parameter int unsigned            WIDTH     = 8,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sclr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_b,
  output logic             tc
);

  localparam logic [2:0] MODE_JK   = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_UP   = 3'b100;
  localparam logic [2:0] MODE_DOWN = 3'b101;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_jk_next;
  logic             w_all_ones;
  logic             w_zero;

  assign w_all_ones = &r_q;
  assign w_zero     = ~|r_q;

  // JK per bit: set where j and q=0, keep where k=0 and q=1 (covers hold/clear/set/toggle)
  assign w_jk_next = (j & ~r_q) | (~k & r_q);

  // Next-state selection for an enabled, non-cleared cycle; reserved modes hold
  always_comb begin
    w_next = r_q;
    case (mode)
      MODE_JK:   w_next = w_jk_next;
      MODE_LOAD: w_next = d;
      MODE_SHL:  w_next = {r_q[WIDTH-2:0], sin};
      MODE_SHR:  w_next = {sin, r_q[WIDTH-1:1]};
`ifdef JK_UNIV_REG_SAT_EN
      MODE_UP:   w_next = w_all_ones ? r_q : r_q + ONE;
      MODE_DOWN: w_next = w_zero     ? r_q : r_q - ONE;
`else
      MODE_UP:   w_next = r_q + ONE;
      MODE_DOWN: w_next = r_q - ONE;
`endif
      default:   w_next = r_q;
    endcase
  end

  // State register: async reset, then sync clear, then enable-gated update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= RESET_VAL;
    end else if (sclr) begin
      r_q <= RESET_VAL;
    end else if (en) begin
      r_q <= w_next;
    end
  end

  assign q   = r_q;
  assign q_b = ~r_q;
  // Terminal count looks only at mode and state, so it is valid even while en=0
  assign tc  = ((mode == MODE_UP) && w_all_ones) || ((mode == MODE_DOWN) && w_zero);

endmodule

// File: tb/tb_jk_univ_reg.sv
// tb/tb_jk_univ_reg.sv - directed self-checking bench for jk_univ_reg (WIDTH=8, RESET_VAL=0)
module tb_jk_univ_reg;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       sclr;
  logic [2:0] mode;
  logic [7:0] j;
  logic [7:0] k;
  logic [7:0] d;
  logic       sin;
  logic [7:0] q;
  logic [7:0] q_b;
  logic       tc;

  int checks;
  int errors;

  jk_univ_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .sclr    (sclr),
    .mode    (mode),
    .j       (j),
    .k       (k),
    .d       (d),
    .sin     (sin),
    .q       (q),
    .q_b     (q_b),
    .tc      (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] val);
    en = 1'b1; sclr = 1'b0; mode = 3'b001; d = val;
    step();
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; en = 1'b0; sclr = 1'b0; mode = 3'b000;
    j = '0; k = '0; d = '0; sin = 1'b0;
    #12;
    check("reset_q",   {24'd0, q},   32'h00);
    check("reset_q_b", {24'd0, q_b}, 32'hFF);
    check("reset_tc",  {31'd0, tc},  32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Asynchronous reset in the middle of a clock period
    load(8'h5A);
    check("load_5a", {24'd0, q}, 32'h5A);
    mode = 3'b100; en = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_q",   {24'd0, q},   32'h00);
    check("async_rst_q_b", {24'd0, q_b}, 32'hFF);
    mode = 3'b101;
    #1;
    check("async_rst_tc_down", {31'd0, tc}, 32'h1);
    step();
    check("rst_held_q", {24'd0, q}, 32'h00);
    @(negedge clk);
    reset_n = 1'b1;

    // JK: all four cases per bit
    load(8'hF0);
    mode = 3'b000; j = 8'hCC; k = 8'hAA; en = 1'b1;
    step();
    check("jk_q",   {24'd0, q},   32'h5C);
    check("jk_q_b", {24'd0, q_b}, 32'hA3);
    j = 8'h00; k = 8'h00;
    step();
    check("jk_hold", {24'd0, q}, 32'h5C);

    // Load then shift
    load(8'h81);
    check("load_81", {24'd0, q}, 32'h81);
    mode = 3'b010; sin = 1'b1;
    step();
    check("shl_1", {24'd0, q}, 32'h03);
    step();
    check("shl_2", {24'd0, q}, 32'h07);
    mode = 3'b011; sin = 1'b0;
    step();
    check("shr_0", {24'd0, q}, 32'h03);
    sin = 1'b1;
    step();
    check("shr_1", {24'd0, q}, 32'h81);

    // Up-count through all-ones
    load(8'hFE);
    mode = 3'b100;
    #1;
    check("up_tc_fe", {31'd0, tc}, 32'h0);
    step();
    check("up_ff",    {24'd0, q},  32'hFF);
    check("up_tc_ff", {31'd0, tc}, 32'h1);
    step();
`ifdef JK_UNIV_REG_SAT_EN
    check("up_sat", {24'd0, q},  32'hFF);
    check("up_sat_tc", {31'd0, tc}, 32'h1);
`else
    check("up_wrap", {24'd0, q},  32'h00);
    check("up_wrap_tc", {31'd0, tc}, 32'h0);
`endif

    // Down-count with enable low, then through zero
    load(8'h01);
    mode = 3'b101; en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      check("down_hold", {24'd0, q}, 32'h01);
    end
    check("down_tc_01", {31'd0, tc}, 32'h0);
    en = 1'b1;
    step();
    check("down_00",    {24'd0, q},  32'h00);
    check("down_tc_00", {31'd0, tc}, 32'h1);
    en = 1'b0;
    #1;
    check("tc_ignores_en", {31'd0, tc}, 32'h1);
    en = 1'b1;
    step();
`ifdef JK_UNIV_REG_SAT_EN
    check("down_sat", {24'd0, q}, 32'h00);
`else
    check("down_wrap", {24'd0, q}, 32'hFF);
`endif

    // Synchronous clear beats en=0 and mode
    load(8'h3C);
    sclr = 1'b1; en = 1'b0; mode = 3'b001; d = 8'hFF;
    step();
    check("sclr_en0", {24'd0, q}, 32'h00);
    sclr = 1'b0;
    load(8'h3C);
    mode = 3'b100; en = 1'b1; sclr = 1'b1;
    step();
    check("sclr_over_up", {24'd0, q}, 32'h00);
    sclr = 1'b0;

    // Reserved modes hold
    load(8'h3C);
    mode = 3'b110; en = 1'b1;
    step();
    check("rsvd_110", {24'd0, q}, 32'h3C);
    mode = 3'b111;
    step();
    check("rsvd_111", {24'd0, q}, 32'h3C);
    check("rsvd_tc",  {31'd0, tc}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
